// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver: parity modes, FSM encodings
// and the baud divisor helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Receive path: 2-flop synchroniser, start-edge detect, mid-bit sampling FSM.
// Emits a single-cycle word strobe with the word and its error flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 line_in,
  output logic                 word_stb,
  output logic [DATA_BITS-1:0] word,
  output logic                 par_err,
  output logic                 frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  logic                 sync1_q, sync2_q, sync3_q;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d;
  logic                 bit_end;
  logic                 exp_par;

  // sync3 is the previous synchronised value, used only for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign exp_par = (PARITY == PAR_ODD) ? ~(^sh_q) : ^sh_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    perr_d    = perr_q;
    word_stb  = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (sync3_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // half a bit after the edge: still low means a real start bit
        if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1))
            state_d = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
          else
            bit_d = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          perr_d  = (sync2_q != exp_par);
          state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        // only the first stop bit is checked; idle again so a start edge
        // inside a second stop bit is still caught
        if (bit_end) begin
          cnt_d     = '0;
          word_stb  = 1'b1;
          frame_err = !sync2_q;
          state_d   = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
    end
  end

  assign word    = sh_q;
  assign par_err = perr_q;

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: TX FSM with valid/ready handshake, loopback mux, and the
// rx_valid / overrun holding register in front of the receive core.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 loopback_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_txd,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(DATA_BITS + 1);

  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == CW'(CPB - 1));
  assign tx_ready   = (tx_state_q == TX_IDLE);

  always_comb begin
    tx_line = 1'b1;
    case (tx_state_q)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_sh_q[0];
      TX_PARITY: tx_line = tx_par_q;
      default:   tx_line = 1'b1;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if (tx_valid) begin
          tx_sh_d    = tx_data;
          tx_par_d   = (PARITY == PAR_ODD) ? ~(^tx_data) : ^tx_data;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          tx_sh_d  = tx_sh_q >> 1;
          if (tx_bit_q == BW'(DATA_BITS - 1)) begin
            tx_bit_d   = '0;
            tx_state_d = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        // tx_bit doubles as the stop-bit index
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BW'(STOP_BITS - 1)) tx_state_d = TX_IDLE;
          else                                tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
    end
  end

  assign uart_txd = loopback_en | tx_line;

  logic                 line_in;
  logic                 word_stb;
  logic [DATA_BITS-1:0] word;
  logic                 word_perr, word_ferr;

  assign line_in = loopback_en ? tx_line : uart_rxd;

  uart_rx_core #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DATA_BITS),
    .PARITY       (PARITY)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_in   (line_in),
    .word_stb  (word_stb),
    .word      (word),
    .par_err   (word_perr),
    .frame_err (word_ferr)
  );

  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 consume;

  assign consume = rx_valid_q && rx_ready;

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = rx_ovr_q;
    if (consume) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
    // a word arriving on the consume cycle takes the freed slot
    if (word_stb) begin
      if (!rx_valid_q || consume) begin
        rx_valid_d = 1'b1;
        rx_data_d  = word;
        rx_perr_d  = word_perr;
        rx_ferr_d  = word_ferr;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench: three configurations (8N1, 8E1, 9O2) at 16 clocks per bit,
// sharing inputs; each test starts from reset and watches one instance.
module tb_uart_transceiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       loopback_en = 1'b0;
  logic       tx_valid = 1'b0;
  logic [8:0] tx_data = '0;
  logic       ext_rxd = 1'b1;
  logic       rx_ready = 1'b0;

  logic       n_tx_ready, n_txd, n_rx_valid, n_perr, n_ferr, n_ovr;
  logic [7:0] n_rx_data;
  logic       e_tx_ready, e_txd, e_rx_valid, e_perr, e_ferr, e_ovr;
  logic [7:0] e_rx_data;
  logic       o_tx_ready, o_txd, o_rx_valid, o_perr, o_ferr, o_ovr;
  logic [8:0] o_rx_data;

  always #5 clk = ~clk;

  uart_transceiver #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
                     .PARITY(0), .STOP_BITS(1)) u_n81 (
    .clk(clk), .rst_n(rst_n), .loopback_en(loopback_en), .tx_data(tx_data[7:0]),
    .tx_valid(tx_valid), .tx_ready(n_tx_ready), .uart_txd(n_txd), .uart_rxd(ext_rxd),
    .rx_data(n_rx_data), .rx_valid(n_rx_valid), .rx_ready(rx_ready),
    .rx_parity_err(n_perr), .rx_frame_err(n_ferr), .rx_overrun(n_ovr));

  uart_transceiver #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
                     .PARITY(1), .STOP_BITS(1)) u_e81 (
    .clk(clk), .rst_n(rst_n), .loopback_en(loopback_en), .tx_data(tx_data[7:0]),
    .tx_valid(tx_valid), .tx_ready(e_tx_ready), .uart_txd(e_txd), .uart_rxd(ext_rxd),
    .rx_data(e_rx_data), .rx_valid(e_rx_valid), .rx_ready(rx_ready),
    .rx_parity_err(e_perr), .rx_frame_err(e_ferr), .rx_overrun(e_ovr));

  uart_transceiver #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(9),
                     .PARITY(2), .STOP_BITS(2)) u_o92 (
    .clk(clk), .rst_n(rst_n), .loopback_en(loopback_en), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(o_tx_ready), .uart_txd(o_txd), .uart_rxd(ext_rxd),
    .rx_data(o_rx_data), .rx_valid(o_rx_valid), .rx_ready(rx_ready),
    .rx_parity_err(o_perr), .rx_frame_err(o_ferr), .rx_overrun(o_ovr));

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_win(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic logic ready_of(input int sel);
    return (sel == 0) ? n_tx_ready : (sel == 1) ? e_tx_ready : o_tx_ready;
  endfunction

  function automatic logic valid_of(input int sel);
    return (sel == 0) ? n_rx_valid : (sel == 1) ? e_rx_valid : o_rx_valid;
  endfunction

  task automatic do_reset();
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    ext_rxd  = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // handshake lands on the posedge after the call finds the selected tx_ready high
  task automatic send(input int sel, input logic [8:0] d);
    int k = 0;
    @(negedge clk);
    while (!ready_of(sel) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) chk("send_timeout", 32'(k), 32'd0);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int sel, input int budget);
    int k = 0;
    @(negedge clk);
    while (!valid_of(sel) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) chk("rx_timeout", 32'(k), 32'd0);
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  task automatic bit_out(input logic v);
    ext_rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pb;
    logic       sb;
    logic       perr;
    logic       ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int rxv_at, rdy_at, busy;
    logic txd_low;

    // even parity: correct parity bit is XOR of the data bits
    vecs[0] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b1};

    // reset state
    #12;
    chk("rst_txd", 32'(n_txd), 32'd1);
    chk("rst_tx_ready", 32'(n_tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(n_rx_valid), 32'd0);
    chk("rst_rx_data", 32'(o_rx_data), 32'd0);
    chk("rst_flags", 32'({n_perr, n_ferr, n_ovr}), 32'd0);
    chk("rst_o_ready", 32'(o_tx_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // loopback 8N1, 0xA5: handshake is cycle 0
    loopback_en = 1'b1;
    send(0, 9'h0A5);
    rxv_at = -1; rdy_at = -1; txd_low = 1'b0;
    for (int k = 1; k <= 220; k++) begin
      @(negedge clk);
      if (n_rx_valid && rxv_at < 0) rxv_at = k;
      if (n_tx_ready && rdy_at < 0) rdy_at = k;
      if (!n_txd) txd_low = 1'b1;
    end
    chk("lb_txd_idle", 32'(txd_low), 32'd0);
    // mid-stop sample near 152, plus a few cycles of synchroniser delay
    chk_win("lb_rx_valid_cycle", rxv_at, 150, 157);
    chk_win("lb_tx_ready_cycle", rdy_at, 161, 161);
    chk("lb_rx_data", 32'(n_rx_data), 32'h0A5);
    chk("lb_flags", 32'({n_perr, n_ferr, n_ovr}), 32'd0);

    // external line, even parity, table-driven
    do_reset();
    loopback_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bit_out(1'b0);
      for (int b = 0; b < 8; b++) bit_out(vecs[i].d[b]);
      bit_out(vecs[i].pb);
      bit_out(vecs[i].sb);
      bit_out(1'b1);
      wait_rx(1, 60);
      chk($sformatf("vec%0d_valid", i), 32'(e_rx_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(e_rx_data), 32'(vecs[i].d));
      chk($sformatf("vec%0d_perr", i), 32'(e_perr), 32'(vecs[i].perr));
      chk($sformatf("vec%0d_ferr", i), 32'(e_ferr), 32'(vecs[i].ferr));
      consume();
    end

    // 6-cycle low glitch on an idle line
    ext_rxd = 1'b0;
    repeat (6) @(posedge clk);
    #1 ext_rxd = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("glitch_no_valid", 32'(e_rx_valid), 32'd0);

    // overrun: two back-to-back frames, no consume
    do_reset();
    loopback_en = 1'b1;
    send(0, 9'h011);
    send(0, 9'h022);
    begin
      int k = 0;
      while (!n_ovr && k < 400) begin
        @(negedge clk);
        k++;
      end
    end
    chk("ovr_flag", 32'(n_ovr), 32'd1);
    chk("ovr_valid", 32'(n_rx_valid), 32'd1);
    chk("ovr_keeps_old", 32'(n_rx_data), 32'h11);
    consume();
    @(negedge clk);
    chk("ovr_consume_valid", 32'(n_rx_valid), 32'd0);
    chk("ovr_consume_clear", 32'(n_ovr), 32'd0);

    // 9 data bits, odd parity, 2 stop bits
    do_reset();
    loopback_en = 1'b1;
    send(2, 9'h1FF);
    busy = 0;
    @(negedge clk);
    while (!o_tx_ready && busy < 400) begin
      busy++;
      @(negedge clk);
    end
    chk("o92_frame_len", 32'(busy), 32'(13 * CPB));
    wait_rx(2, 100);
    chk("o92_rx_data", 32'(o_rx_data), 32'h1FF);
    chk("o92_flags", 32'({o_perr, o_ferr}), 32'd0);

    // async reset mid-DATA
    do_reset();
    loopback_en = 1'b0;
    send(0, 9'h000);
    repeat (40) @(negedge clk);
    chk("mid_txd_low", 32'(n_txd), 32'd0);
    chk("mid_tx_busy", 32'(n_tx_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_txd", 32'(n_txd), 32'd1);
    chk("async_rst_ready", 32'(n_tx_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    loopback_en = 1'b1;
    send(0, 9'h042);
    wait_rx(0, 300);
    chk("post_rst_data", 32'(n_rx_data), 32'h42);
    chk("post_rst_flags", 32'({n_perr, n_ferr, n_ovr}), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
